// File: rtl/rob_pkg.sv
// -----------------------------------------------------------------------------
// rob_pkg -- types shared by the ROB front-end blocks.
//   ar_state_e : AR front-stage FSM states (IDLE/ALLOC/SEND)
//   ar_req_t   : held AR request (id, addr, len, size, burst)
//   uid_width  : unique-ID width derivation shared with allocator_tag_map
// -----------------------------------------------------------------------------
package rob_pkg;

   localparam int AR_ID_W   = 4;
   localparam int AR_ADDR_W = 32;
   localparam int AR_LEN_W  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ALLOC = 2'd1,
      SEND  = 2'd2
   } ar_state_e;

   typedef struct packed {
      logic [AR_ID_W-1:0]   id;
      logic [AR_ADDR_W-1:0] addr;
      logic [AR_LEN_W-1:0]  len;
      logic [2:0]           size;
      logic [1:0]           burst;
   } ar_req_t;

   // Unique ID = row index concatenated with column index in the allocator.
   function automatic int uid_width(input int row_w, input int col_w);
      return row_w + col_w;
   endfunction

endpackage

// File: rtl/ar_id_remap.sv
// -----------------------------------------------------------------------------
// ar_id_remap -- AR-channel front stage of the ROB.
// Accepts one AXI read-address request at a time, obtains a unique ID from the
// allocator, emits a one-cycle metadata pulse on grant and forwards the request
// downstream with ARID replaced by the unique ID.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ar_in_*                  upstream AR channel (valid/ready/id/addr/len/size/burst)
//   ar_out_*                 downstream AR channel, id = remapped unique ID
//   alloc_req/alloc_in_id    request to allocator with held ARID
//   alloc_gnt/alloc_uid      combinational grant + unique ID from allocator
//   meta_valid/uid/len       one-cycle pulse on grant for ROB slot reservation
//   stall_cnt                cycles spent waiting for a grant (saturating);
//                            present only when AR_REMAP_STALL_CNT_EN is defined
// -----------------------------------------------------------------------------
module ar_id_remap
   import rob_pkg::*;
#(
   parameter int ID_WIDTH = AR_ID_W,
   parameter int UID_W    = uid_width(2, 2),
   parameter int ADDR_W   = AR_ADDR_W,
   parameter int LEN_W    = AR_LEN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ar_in_valid,
   output logic              ar_in_ready,
   input  logic [ID_WIDTH-1:0] ar_in_id,
   input  logic [ADDR_W-1:0] ar_in_addr,
   input  logic [LEN_W-1:0]  ar_in_len,
   input  logic [2:0]        ar_in_size,
   input  logic [1:0]        ar_in_burst,
   output logic              ar_out_valid,
   input  logic              ar_out_ready,
   output logic [UID_W-1:0]  ar_out_id,
   output logic [ADDR_W-1:0] ar_out_addr,
   output logic [LEN_W-1:0]  ar_out_len,
   output logic [2:0]        ar_out_size,
   output logic [1:0]        ar_out_burst,
   output logic              alloc_req,
   output logic [ID_WIDTH-1:0] alloc_in_id,
   input  logic              alloc_gnt,
   input  logic [UID_W-1:0]  alloc_uid,
   output logic              meta_valid,
   output logic [UID_W-1:0]  meta_uid,
   output logic [LEN_W-1:0]  meta_len
`ifdef AR_REMAP_STALL_CNT_EN
  ,output logic [15:0]       stall_cnt
`endif
);

   ar_state_e        state, state_nxt;
   ar_req_t          hold;
   logic [UID_W-1:0] uid_q;
   logic             capture;
   logic             uid_ld;

   // Next state and decoded outputs. Reset forces every handshake output low
   // so nothing leaks out while the stage is being cleared.
   always_comb begin
      state_nxt    = state;
      capture      = 1'b0;
      uid_ld       = 1'b0;
      ar_in_ready  = 1'b0;
      alloc_req    = 1'b0;
      meta_valid   = 1'b0;
      ar_out_valid = 1'b0;
      case (state)
         IDLE: begin
            ar_in_ready = 1'b1;
            if (ar_in_valid) begin
               capture   = 1'b1;
               state_nxt = ALLOC;
            end
         end
         ALLOC: begin
            alloc_req = 1'b1;
            if (alloc_gnt) begin
               meta_valid = 1'b1;
               uid_ld     = 1'b1;
               state_nxt  = SEND;
            end
         end
         SEND: begin
            ar_out_valid = 1'b1;
            // Accepting on the send cycle avoids an IDLE bubble.
            ar_in_ready  = ar_out_ready;
            if (ar_out_ready) begin
               capture   = ar_in_valid;
               state_nxt = ar_in_valid ? ALLOC : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      if (rst) begin
         ar_in_ready  = 1'b0;
         alloc_req    = 1'b0;
         meta_valid   = 1'b0;
         ar_out_valid = 1'b0;
         capture      = 1'b0;
         uid_ld       = 1'b0;
         state_nxt    = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         hold  <= '0;
         uid_q <= '0;
      end else begin
         state <= state_nxt;
         if (capture) begin
            hold.id    <= AR_ID_W'(ar_in_id);
            hold.addr  <= AR_ADDR_W'(ar_in_addr);
            hold.len   <= AR_LEN_W'(ar_in_len);
            hold.size  <= ar_in_size;
            hold.burst <= ar_in_burst;
         end
         if (uid_ld) uid_q <= alloc_uid;
      end
   end

   assign alloc_in_id  = ID_WIDTH'(hold.id);
   assign ar_out_id    = uid_q;
   assign ar_out_addr  = ADDR_W'(hold.addr);
   assign ar_out_len   = LEN_W'(hold.len);
   assign ar_out_size  = hold.size;
   assign ar_out_burst = hold.burst;

   // Metadata is combinational so the ROB reserves the slot in the grant cycle.
   assign meta_uid = meta_valid ? alloc_uid : '0;
   assign meta_len = meta_valid ? LEN_W'(hold.len) : '0;

`ifdef AR_REMAP_STALL_CNT_EN
   logic [15:0] stall_q;
   always_ff @(posedge clk) begin
      if (rst)
         stall_q <= '0;
      else if (state == ALLOC && !alloc_gnt && stall_q != 16'hFFFF)
         stall_q <= stall_q + 16'd1;
   end
   assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_ar_id_remap.sv
module tb_ar_id_remap;

   logic        clk = 1'b0;
   logic        rst;
   logic        ar_in_valid, ar_in_ready;
   logic [3:0]  ar_in_id;
   logic [31:0] ar_in_addr;
   logic [7:0]  ar_in_len;
   logic [2:0]  ar_in_size;
   logic [1:0]  ar_in_burst;
   logic        ar_out_valid, ar_out_ready;
   logic [3:0]  ar_out_id;
   logic [31:0] ar_out_addr;
   logic [7:0]  ar_out_len;
   logic [2:0]  ar_out_size;
   logic [1:0]  ar_out_burst;
   logic        alloc_req;
   logic [3:0]  alloc_in_id;
   logic        alloc_gnt;
   logic [3:0]  alloc_uid;
   logic        meta_valid;
   logic [3:0]  meta_uid;
   logic [7:0]  meta_len;
`ifdef AR_REMAP_STALL_CNT_EN
   logic [15:0] stall_cnt;
`endif

   ar_id_remap dut (
      .clk(clk), .rst(rst),
      .ar_in_valid(ar_in_valid), .ar_in_ready(ar_in_ready), .ar_in_id(ar_in_id),
      .ar_in_addr(ar_in_addr), .ar_in_len(ar_in_len), .ar_in_size(ar_in_size),
      .ar_in_burst(ar_in_burst),
      .ar_out_valid(ar_out_valid), .ar_out_ready(ar_out_ready), .ar_out_id(ar_out_id),
      .ar_out_addr(ar_out_addr), .ar_out_len(ar_out_len), .ar_out_size(ar_out_size),
      .ar_out_burst(ar_out_burst),
      .alloc_req(alloc_req), .alloc_in_id(alloc_in_id), .alloc_gnt(alloc_gnt),
      .alloc_uid(alloc_uid),
      .meta_valid(meta_valid), .meta_uid(meta_uid), .meta_len(meta_len)
`ifdef AR_REMAP_STALL_CNT_EN
     ,.stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [3:0]  uid;
   } txn_t;

   // Reference model: requests accepted but not yet granted, and granted
   // requests not yet handed downstream.
   txn_t pend_q[$];
   txn_t out_q[$];
   int   n_chk = 0, n_pass = 0;
   int   n_acc = 0, n_meta = 0, n_drop = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin : mon
      txn_t t;
      logic exp_rdy;
      if (rst) begin
         chk("rst_in_ready", ar_in_ready, 0);
         chk("rst_alloc_req", alloc_req, 0);
         chk("rst_meta_valid", meta_valid, 0);
         chk("rst_out_valid", ar_out_valid, 0);
         n_drop += pend_q.size();
         pend_q.delete();
         out_q.delete();
      end else begin
         if (meta_valid) n_meta++;
         exp_rdy = (pend_q.size() == 0 && out_q.size() == 0) ||
                   (out_q.size() != 0 && ar_out_ready);
         chk("in_ready", ar_in_ready, exp_rdy);
         chk("out_valid", ar_out_valid, out_q.size() != 0);
         if (out_q.size() != 0 && ar_out_valid) begin
            t = out_q[0];
            chk("out_id", ar_out_id, t.uid);
            chk("out_addr", ar_out_addr, t.addr);
            chk("out_len", ar_out_len, t.len);
            chk("out_size", ar_out_size, t.size);
            chk("out_burst", ar_out_burst, t.burst);
            if (ar_out_ready) void'(out_q.pop_front());
         end
         chk("alloc_req", alloc_req, pend_q.size() != 0);
         if (pend_q.size() != 0) begin
            chk("alloc_in_id", alloc_in_id, pend_q[0].id);
            chk("meta_valid", meta_valid, alloc_gnt);
            if (alloc_gnt) begin
               chk("meta_uid", meta_uid, alloc_uid);
               chk("meta_len", meta_len, pend_q[0].len);
               t = pend_q.pop_front();
               t.uid = alloc_uid;
               out_q.push_back(t);
            end
         end else begin
            chk("meta_idle", meta_valid, 0);
         end
         if (ar_in_valid && ar_in_ready) begin
            t.id = ar_in_id; t.addr = ar_in_addr; t.len = ar_in_len;
            t.size = ar_in_size; t.burst = ar_in_burst; t.uid = 4'h0;
            pend_q.push_back(t);
            n_acc++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input logic [3:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst);
      ar_in_valid = 1'b1; ar_in_id = id; ar_in_addr = addr;
      ar_in_len = len; ar_in_size = size; ar_in_burst = burst;
   endtask

   initial begin : stim
      logic hs;
      rst = 1'b1;
      ar_in_valid = 0; ar_in_id = 0; ar_in_addr = 0; ar_in_len = 0;
      ar_in_size = 0; ar_in_burst = 0; ar_out_ready = 0; alloc_gnt = 0; alloc_uid = 0;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", ar_in_ready, 1);
      chk("post_rst_addr", ar_out_addr, 0);
      chk("post_rst_meta_len", meta_len, 0);
`ifdef AR_REMAP_STALL_CNT_EN
      chk("post_rst_stall", stall_cnt, 0);
`endif

      // Single request with immediate grant: meta in cycle 1, out in cycle 2.
      step();
      drive_req(4'h3, 32'hA000_1234, 8'd7, 3'd2, 2'd1);
      alloc_gnt = 1; alloc_uid = 4'h0; ar_out_ready = 1;
      @(negedge clk);
      chk("single_accept", ar_in_ready, 1);
      step(); ar_in_valid = 0;
      @(negedge clk);
      chk("single_meta", meta_valid, 1);
      chk("single_meta_len", meta_len, 8'd7);
      step();
      @(negedge clk);
      chk("single_out_valid", ar_out_valid, 1);
      chk("single_out_id", ar_out_id, 4'h0);
      chk("single_out_addr", ar_out_addr, 32'hA000_1234);
      step();

      // Grant withheld five cycles.
      alloc_gnt = 0;
      drive_req(4'h6, 32'h0000_0040, 8'd3, 3'd3, 2'd1);
      step(); ar_in_valid = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("wait_alloc_req", alloc_req, 1);
         chk("wait_ready", ar_in_ready, 0);
         step();
      end
      alloc_gnt = 1; alloc_uid = 4'h5; ar_out_ready = 0;
      @(negedge clk);
      chk("wait_grant_req", alloc_req, 1);
      chk("wait_grant_meta", meta_valid, 1);
      step();
`ifdef AR_REMAP_STALL_CNT_EN
      chk("stall_cnt_5", stall_cnt, 16'd5);
`endif

      // Backpressure in SEND, with a second request already waiting.
      drive_req(4'hB, 32'hDEAD_BEE0, 8'd15, 3'd1, 2'd2);
      alloc_uid = 4'h9;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_out_valid", ar_out_valid, 1);
         chk("bp_out_id", ar_out_id, 4'h5);
         chk("bp_ready", ar_in_ready, 0);
         chk("bp_alloc_req", alloc_req, 0);
         step();
      end
      // Back-to-back: handshake out and accept in the same cycle.
      ar_out_ready = 1;
      @(negedge clk);
      chk("b2b_ready", ar_in_ready, 1);
      step(); ar_in_valid = 0;
      @(negedge clk);
      chk("b2b_no_bubble", alloc_req, 1);
      chk("b2b_meta_uid", meta_uid, 4'h9);
      step();
      @(negedge clk);
      chk("b2b_out_id", ar_out_id, 4'h9);
      step();

      // Reset while in ALLOC.
      alloc_gnt = 0;
      drive_req(4'h2, 32'h1111_0000, 8'd1, 3'd0, 2'd0);
      step(); ar_in_valid = 0;
      @(negedge clk);
      chk("pre_rst_alloc", alloc_req, 1);
      step(); rst = 1;
      step(); rst = 0;
      @(negedge clk);
      chk("rstalloc_req", alloc_req, 0);
      chk("rstalloc_out", ar_out_valid, 0);
      chk("rstalloc_ready", ar_in_ready, 1);
`ifdef AR_REMAP_STALL_CNT_EN
      chk("rstalloc_stall", stall_cnt, 0);
`endif

      // Spurious grant in IDLE.
      step(); alloc_gnt = 1; alloc_uid = 4'hE;
      @(negedge clk);
      chk("spur_meta", meta_valid, 0);
      step();
      @(negedge clk);
      chk("spur_ready", ar_in_ready, 1);
      chk("spur_alloc_req", alloc_req, 0);

      // Randomized traffic; the monitor checks every cycle.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         hs = ar_in_valid && ar_in_ready;
         @(posedge clk); #1;
         rst = ($urandom_range(0, 299) == 0);
         if (!ar_in_valid || hs) begin
            ar_in_valid = ($urandom_range(0, 2) != 0);
            ar_in_id    = 4'($urandom);
            ar_in_addr  = $urandom;
            ar_in_len   = 8'($urandom);
            ar_in_size  = 3'($urandom);
            ar_in_burst = 2'($urandom);
         end
         alloc_gnt    = ($urandom_range(0, 2) == 0);
         alloc_uid    = 4'($urandom);
         ar_out_ready = ($urandom_range(0, 1) == 1);
      end

      // Drain.
      rst = 0; ar_in_valid = 0; alloc_gnt = 1; ar_out_ready = 1;
      repeat (6) step();
      @(negedge clk);
      chk("drain_pend", pend_q.size(), 0);
      chk("drain_out", out_q.size(), 0);
      chk("meta_once_per_req", n_meta, n_acc - n_drop);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
